// File: rtl/rtc_bus_if.sv
// Bus bundle between the control FSM / RTC chip pins and rtc_bus_sequencer.
// The master modport is the sequencer side; the slave modport is the control/pin side.
interface rtc_bus_if;
    logic       start_wr;
    logic       start_rd;
    logic [7:0] dir;
    logic [7:0] dato_wr;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad;
    logic [7:0] dato_rd;
    logic [7:0] dir_rd;
    logic       strobe_rd;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        input  start_wr, start_rd, dir, dato_wr, bus_in,
        output bus_out, bus_oe, cs_n, wr_n, rd_n, ad,
        output dato_rd, dir_rd, strobe_rd, busy, done, error
    );

    modport slave (
        output start_wr, start_rd, dir, dato_wr, bus_in,
        input  bus_out, bus_oe, cs_n, wr_n, rd_n, ad,
        input  dato_rd, dir_rd, strobe_rd, busy, done, error
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Address/data multiplexed bus sequencer for the external RTC chip.
// Optional packed-BCD check of write data is enabled by defining RTC_BCD_CHECK_EN.
module rtc_bus_sequencer #(
    parameter int unsigned T_GAP   = 4,
    parameter int unsigned T_PULSE = 10
) (
    input  logic       clk,
    input  logic       reset,
    rtc_bus_if.master  bus
);

    localparam int unsigned MAX_LEN = (T_GAP > T_PULSE) ? T_GAP : T_PULSE;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_rd_q, op_rd_d;
    logic [7:0]       dir_q, dir_d;
    logic [7:0]       data_q, data_d;
    logic             phase_last;

    logic [7:0] bus_out_d, dato_rd_d, dir_rd_d;
    logic       bus_oe_d, cs_n_d, wr_n_d, rd_n_d, ad_d;
    logic       strobe_rd_d, busy_d, done_d, error_d;

`ifdef RTC_BCD_CHECK_EN
    logic bcd_bad;
    assign bcd_bad = (bus.dato_wr[7:4] > 4'd9) || (bus.dato_wr[3:0] > 4'd9);
`endif

    // End of the current phase, from the shared phase counter
    always_comb begin
        unique case (state_q)
            A_STROBE, D_STROBE: phase_last = (cnt_q == PULSE_LAST);
            DONE, IDLE:         phase_last = 1'b1;
            default:            phase_last = (cnt_q == GAP_LAST);
        endcase
    end

    // Next state, latched request, read capture, and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_rd_d     = op_rd_q;
        dir_d       = dir_q;
        data_d      = data_q;
        dato_rd_d   = bus.dato_rd;
        dir_rd_d    = bus.dir_rd;
        strobe_rd_d = 1'b0;
        done_d      = 1'b0;
        error_d     = bus.error;

        if (state_q == IDLE) begin
            if (bus.start_wr) begin
`ifdef RTC_BCD_CHECK_EN
                if (bcd_bad) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = A_SETUP;
                    cnt_d   = '0;
                    op_rd_d = 1'b0;
                    dir_d   = bus.dir;
                    data_d  = bus.dato_wr;
                end
`else
                state_d = A_SETUP;
                cnt_d   = '0;
                op_rd_d = 1'b0;
                dir_d   = bus.dir;
                data_d  = bus.dato_wr;
`endif
            end else if (bus.start_rd) begin
                state_d = A_SETUP;
                cnt_d   = '0;
                op_rd_d = 1'b1;
                dir_d   = bus.dir;
            end
        end else if (phase_last) begin
            cnt_d = '0;
            unique case (state_q)
                A_SETUP:  state_d = A_STROBE;
                A_STROBE: state_d = A_HOLD;
                A_HOLD:   state_d = D_SETUP;
                D_SETUP:  state_d = D_STROBE;
                D_STROBE: state_d = D_HOLD;
                D_HOLD:   state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Read data is taken on the last cycle the read strobe is low
        if (state_q == D_STROBE && phase_last && op_rd_q) begin
            dato_rd_d   = bus.bus_in;
            dir_rd_d    = dir_q;
            strobe_rd_d = 1'b1;
        end

        if (state_d == DONE) done_d = 1'b1;

`ifndef RTC_BCD_CHECK_EN
        error_d = 1'b0;
`endif

        cs_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        ad_d      = 1'b1;
        bus_oe_d  = 1'b0;
        bus_out_d = 8'h00;
        busy_d    = (state_d != IDLE);

        unique case (state_d)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_n_d    = 1'b0;
                ad_d      = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = dir_d;
                wr_n_d    = (state_d != A_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_n_d = 1'b0;
                if (op_rd_d) begin
                    rd_n_d = (state_d != D_STROBE);
                end else begin
                    bus_oe_d  = 1'b1;
                    bus_out_d = data_d;
                    wr_n_d    = (state_d != D_STROBE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_rd_q       <= 1'b0;
            dir_q         <= 8'h00;
            data_q        <= 8'h00;
            bus.bus_out   <= 8'h00;
            bus.bus_oe    <= 1'b0;
            bus.cs_n      <= 1'b1;
            bus.wr_n      <= 1'b1;
            bus.rd_n      <= 1'b1;
            bus.ad        <= 1'b1;
            bus.dato_rd   <= 8'h00;
            bus.dir_rd    <= 8'h00;
            bus.strobe_rd <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_rd_q       <= op_rd_d;
            dir_q         <= dir_d;
            data_q        <= data_d;
            bus.bus_out   <= bus_out_d;
            bus.bus_oe    <= bus_oe_d;
            bus.cs_n      <= cs_n_d;
            bus.wr_n      <= wr_n_d;
            bus.rd_n      <= rd_n_d;
            bus.ad        <= ad_d;
            bus.dato_rd   <= dato_rd_d;
            bus.dir_rd    <= dir_rd_d;
            bus.strobe_rd <= strobe_rd_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
            bus.error     <= error_d;
        end
    end

endmodule
